// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - execute-stage ALU with single-cycle logic/arith ops and iterative unsigned MULU/DIVU
// Optional build macro ALU_MUL_EARLY_EXIT_EN: MULU stops once the remaining multiplier bits are all zero.
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ctl,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MULU = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state_q, state_d;

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [CNT_W-1:0]   count_q;

  logic               is_sub;
  logic               is_multi;
  logic [WIDTH-1:0]   b_op;
  logic [WIDTH:0]     add_full;
  logic [WIDTH-1:0]   add_low;
  logic               add_ovf;
  logic               alu_ovf;
  logic [WIDTH-1:0]   alu_res;

  logic [2*WIDTH-1:0] prod_next;
  logic               mul_last;
  logic               div_last;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quot_next;

  // Single-cycle datapath; SLT reuses the subtractor so extremes resolve correctly.
  always_comb begin
    is_sub   = (ctl == OP_SUB) || (ctl == OP_SLT);
    is_multi = (ctl == OP_MULU) || (ctl == OP_DIVU);
    b_op     = is_sub ? ~data_b : data_b;
    add_full = {1'b0, data_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    add_low  = {1'b0, data_a[WIDTH-2:0]} + {1'b0, b_op[WIDTH-2:0]}
             + {{(WIDTH-1){1'b0}}, is_sub};
    add_ovf  = add_low[WIDTH-1] ^ add_full[WIDTH];
    alu_ovf  = 1'b0;
    case (ctl)
      OP_OR:  alu_res = data_a | data_b;
      OP_ADD, OP_SUB: begin
        alu_res = add_full[WIDTH-1:0];
        alu_ovf = add_ovf;
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, add_full[WIDTH-1] ^ add_ovf};
      default: alu_res = data_a & data_b;
    endcase
  end

  always_comb begin
    prod_next = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
`ifdef ALU_MUL_EARLY_EXIT_EN
    mul_last  = (count_q == LAST_ITER) || (mplier_q[WIDTH-1:1] == '0);
`else
    mul_last  = (count_q == LAST_ITER);
`endif
    div_last  = (count_q == LAST_ITER);
    // Restoring step: a zero divisor always "fits", yielding all-ones quotient and remainder = dividend.
    div_shift = {rem_q, quot_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, divisor_q};
    div_ge    = (div_shift >= {1'b0, divisor_q});
    rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quot_next = {quot_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && (ctl == OP_MULU)) begin
          state_d = MUL;
        end else if (start && (ctl == OP_DIVU)) begin
          state_d = DIV;
        end
      end
      MUL:     if (mul_last) state_d = DONE;
      DIV:     if (div_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q   <= '0;
      prod_q    <= '0;
      mplier_q  <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      count_q   <= '0;
      result_lo <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand_q   <= {{WIDTH{1'b0}}, data_a};
            mplier_q  <= data_b;
            prod_q    <= '0;
            quot_q    <= data_a;
            rem_q     <= '0;
            divisor_q <= data_b;
            count_q   <= '0;
            div_zero  <= 1'b0;
            if (is_multi) begin
              busy <= 1'b1;
            end else begin
              result_lo <= alu_res;
              result_hi <= '0;
              zero      <= (alu_res == '0);
              overflow  <= alu_ovf;
              done      <= 1'b1;
            end
          end
        end
        MUL: begin
          prod_q   <= prod_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CNT_ONE;
          if (mul_last) begin
            {result_hi, result_lo} <= prod_next;
            zero     <= (prod_next[WIDTH-1:0] == '0);
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        DIV: begin
          rem_q   <= rem_next;
          quot_q  <= quot_next;
          count_q <= count_q + CNT_ONE;
          if (div_last) begin
            result_lo <= quot_next;
            result_hi <= rem_next;
            zero      <= (quot_next == '0);
            overflow  <= 1'b0;
            div_zero  <= (divisor_q == '0);
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - self-checking bench for alu_muldiv_seq at WIDTH=8 (honours ALU_MUL_EARLY_EXIT_EN)
module tb_alu_muldiv_seq;

  localparam int W    = 8;
  localparam int MAXS = 2 ** (W - 1) - 1;
  localparam int MINS = -(2 ** (W - 1));

  localparam logic [2:0] C_AND = 3'b000;
  localparam logic [2:0] C_OR  = 3'b001;
  localparam logic [2:0] C_ADD = 3'b010;
  localparam logic [2:0] C_MUL = 3'b011;
  localparam logic [2:0] C_DIV = 3'b100;
  localparam logic [2:0] C_RSV = 3'b101;
  localparam logic [2:0] C_SUB = 3'b110;
  localparam logic [2:0] C_SLT = 3'b111;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   ctl = 3'b000;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         overflow;
  logic         div_zero;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .ctl(ctl),
    .data_a(data_a), .data_b(data_b),
    .result_lo(result_lo), .result_hi(result_hi),
    .zero(zero), .overflow(overflow), .div_zero(div_zero),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         z;
    logic         v;
    logic         dz;
  } res_t;

  function automatic res_t model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    int sa, sb, s;
    logic [2*W-1:0] p;
    r  = '0;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (c)
      C_OR:  r.lo = a | b;
      C_ADD: begin s = sa + sb; r.lo = a + b; r.v = (s > MAXS) || (s < MINS); end
      C_SUB: begin s = sa - sb; r.lo = a - b; r.v = (s > MAXS) || (s < MINS); end
      C_SLT: r.lo = (sa < sb) ? W'(1) : W'(0);
      C_MUL: begin p = (2*W)'(a) * (2*W)'(b); r.lo = p[W-1:0]; r.hi = p[2*W-1:W]; end
      C_DIV: begin
        if (b == '0) begin r.lo = '1; r.hi = a; r.dz = 1'b1; end
        else begin r.lo = a / b; r.hi = a % b; end
      end
      default: r.lo = a & b;
    endcase
    r.z = (r.lo == '0);
    return r;
  endfunction

  // Iterations a multicycle op spends busy; 0 marks a single-cycle op.
  function automatic int iters_of(input logic [2:0] c, input logic [W-1:0] b);
    if (c == C_DIV) return W;
    if (c != C_MUL) return 0;
`ifdef ALU_MUL_EARLY_EXIT_EN
    begin
      int n;
      n = 1;
      for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
      return n;
    end
`else
    return W;
`endif
  endfunction

  // Model state, indexed by rising-edge number.
  int   cyc = 0;
  res_t m_res = '0;
  res_t p_res = '0;
  logic p_valid = 1'b0;
  int   p_edge = -1;
  int   done_edge = -1;
  int   busy_from = 1;
  int   busy_to = 0;
  int   free_at = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_res     <= '0;
      p_valid   <= 1'b0;
      busy_from <= 1;
      busy_to   <= 0;
      done_edge <= -1;
      free_at   <= cyc + 2;
    end else if (p_valid && (cyc + 1 == p_edge)) begin
      m_res   <= p_res;
      p_valid <= 1'b0;
    end else if (start && (cyc + 1 >= free_at)) begin
      if (iters_of(ctl, data_b) == 0) begin
        m_res     <= model(ctl, data_a, data_b);
        done_edge <= cyc + 1;
        free_at   <= cyc + 2;
      end else begin
        p_res     <= model(ctl, data_a, data_b);
        p_valid   <= 1'b1;
        m_res.dz  <= 1'b0;
        p_edge    <= cyc + 1 + iters_of(ctl, data_b);
        done_edge <= cyc + 1 + iters_of(ctl, data_b);
        busy_from <= cyc + 1;
        busy_to   <= cyc + iters_of(ctl, data_b);
        free_at   <= cyc + 3 + iters_of(ctl, data_b);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("done",      64'(done),      64'(cyc == done_edge));
      chk("busy",      64'(busy),      64'((cyc >= busy_from) && (cyc <= busy_to)));
      chk("result_lo", 64'(result_lo), 64'(m_res.lo));
      chk("result_hi", 64'(result_hi), 64'(m_res.hi));
      chk("zero",      64'(zero),      64'(m_res.z));
      chk("overflow",  64'(overflow),  64'(m_res.v));
      chk("div_zero",  64'(div_zero),  64'(m_res.dz));
    end
  end

  // One-cycle start, operands scrambled after acceptance, then wait for done.
  task automatic run_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clk);
    start = 1'b1; ctl = c; data_a = a; data_b = b;
    @(negedge clk);
    start = 1'b0; ctl = ~c; data_a = ~a; data_b = b ^ 8'h5A;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int exp_lat;
    repeat (2) @(negedge clk);
    chk("rst_lo", 64'(result_lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    run_op(C_ADD, 8'h7F, 8'h01, lat);
    chk("add_lat", 64'(lat), 64'd1);
    chk("add_lo", 64'(result_lo), 64'h80);
    chk("add_ovf", 64'(overflow), 64'd1);
    chk("add_zero", 64'(zero), 64'd0);

    run_op(C_SUB, 8'h05, 8'h05, lat);
    chk("sub_lo", 64'(result_lo), 64'h00);
    chk("sub_zero", 64'(zero), 64'd1);
    run_op(C_SUB, 8'h80, 8'h01, lat);
    chk("sub_wrap_lo", 64'(result_lo), 64'h7F);
    chk("sub_wrap_ovf", 64'(overflow), 64'd1);
    run_op(C_SLT, 8'h80, 8'h7F, lat);
    chk("slt_neg", 64'(result_lo), 64'h01);
    run_op(C_SLT, 8'h7F, 8'h80, lat);
    chk("slt_pos", 64'(result_lo), 64'h00);
    run_op(C_AND, 8'hF0, 8'h3C, lat);
    chk("and_lo", 64'(result_lo), 64'h30);
    run_op(C_OR, 8'hF0, 8'h3C, lat);
    chk("or_lo", 64'(result_lo), 64'hFC);
    run_op(C_RSV, 8'h7F, 8'h01, lat);
    chk("rsv_lo", 64'(result_lo), 64'h01);
    chk("rsv_ovf", 64'(overflow), 64'd0);

    run_op(C_MUL, 8'hFF, 8'hFF, lat);
    chk("mul_ff_lat", 64'(lat), 64'd9);
    chk("mul_ff_lo", 64'(result_lo), 64'h01);
    chk("mul_ff_hi", 64'(result_hi), 64'hFE);
    run_op(C_DIV, 8'd200, 8'd7, lat);
    chk("div_lat", 64'(lat), 64'd9);
    chk("div_q", 64'(result_lo), 64'h1C);
    chk("div_r", 64'(result_hi), 64'h04);
    chk("div_dz", 64'(div_zero), 64'd0);
    run_op(C_DIV, 8'h5A, 8'h00, lat);
    chk("div0_q", 64'(result_lo), 64'hFF);
    chk("div0_r", 64'(result_hi), 64'h5A);
    chk("div0_dz", 64'(div_zero), 64'd1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; ctl = C_MUL; data_a = 8'h55; data_b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_lo", 64'(result_lo), 64'd0);
    chk("midrst_hi", 64'(result_hi), 64'd0);
    rst = 1'b0; start = 1'b1; ctl = C_ADD; data_a = 8'h02; data_b = 8'h03;
    @(negedge clk);
    start = 1'b0;
    chk("postrst_done", 64'(done), 64'd1);
    chk("postrst_lo", 64'(result_lo), 64'h05);

`ifdef ALU_MUL_EARLY_EXIT_EN
    exp_lat = 3;
`else
    exp_lat = 9;
`endif
    run_op(C_MUL, 8'h23, 8'h03, lat);
    chk("mul_23_lat", 64'(lat), 64'(exp_lat));
    chk("mul_23_lo", 64'(result_lo), 64'h69);
    chk("mul_23_hi", 64'(result_hi), 64'h00);
`ifdef ALU_MUL_EARLY_EXIT_EN
    exp_lat = 2;
`else
    exp_lat = 9;
`endif
    run_op(C_MUL, 8'h12, 8'h00, lat);
    chk("mul_0_lat", 64'(lat), 64'(exp_lat));
    chk("mul_0_lo", 64'(result_lo), 64'h00);
    chk("mul_0_zero", 64'(zero), 64'd1);

    // start held high with a new opcode while the multiply runs.
`ifdef ALU_MUL_EARLY_EXIT_EN
    exp_lat = 6;
`else
    exp_lat = 9;
`endif
    @(negedge clk);
    start = 1'b1; ctl = C_MUL; data_a = 8'h10; data_b = 8'h10;
    @(negedge clk);
    ctl = C_ADD; data_a = 8'h01; data_b = 8'h02;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("held_lat", 64'(lat), 64'(exp_lat));
    chk("held_mul_lo", 64'(result_lo), 64'h00);
    chk("held_mul_hi", 64'(result_hi), 64'h01);
    @(negedge clk);
    chk("held_gap_done", 64'(done), 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("held_add_done", 64'(done), 64'd1);
    chk("held_add_lo", 64'(result_lo), 64'h03);
    chk("held_add_hi", 64'(result_hi), 64'h00);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Parametrised WIDTH-bit execute-stage ALU for the 5-stage pipeline.
- Keeps the single-cycle AND/OR/ADD/SUB/SLT datapath and adds iterative unsigned multiply and divide. These run under a start/busy/done handshake so the hazard unit can stall EX.
- All results are registered; the 64-bit (2*WIDTH) mul/div result is split into result_lo and result_hi, which feed the HI/LO registers.

Parameters:
- WIDTH, 32, operand and result width; legal range 4..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  operation request; sampled only in IDLE.
- ctl  in  3  opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 MULU, 100 DIVU; 101 reserved.
- data_a  in  WIDTH  operand A (multiplicand / dividend).
- data_b  in  WIDTH  operand B (multiplier / divisor).
- result_lo  out  WIDTH  ALU result, product low half, or quotient.
- result_hi  out  WIDTH  product high half or remainder; 0 for single-cycle ops.
- zero  out  1  result_lo == 0.
- overflow  out  1  signed overflow of ADD/SUB; 0 otherwise.
- div_zero  out  1  DIVU with data_b == 0.
- busy  out  1  multicycle op in progress.
- done  out  1  one-cycle pulse: results valid.

Behaviour:
- Reset (sync): state=IDLE; every output is 0; counter and internal registers are 0. Reset asserted mid-operation aborts it, and no done pulse is produced.
- States: IDLE, MUL, DIV, DONE.
- Operands and ctl are latched when start is accepted (start=1 in IDLE). They may change afterwards with no effect on the result.
- Single-cycle ops (AND/OR/ADD/SUB/SLT), start accepted at edge E:
  - result_lo, zero, overflow and done=1 are registered at E+1; result_hi=0; state stays IDLE.
  - Back-to-back starts are legal every cycle.
- Arithmetic rules:
  - SUB = A + ~B + 1.
  - SLT = 1 if signed A < signed B, computed from sign(A-B) XOR overflow, so it is correct at the extremes.
  - ADD/SUB results wrap modulo 2^WIDTH.
  - overflow = (carry into MSB) XOR (carry out).
- MULU, start at E:
  - Enter MUL with product=0 and count=0.
  - Each cycle: if multiplier[0], add multiplicand to product (2*WIDTH-bit adder); multiplicand shifts left by 1, multiplier shifts right by 1, count increments.
  - After WIDTH iterations, go to DONE. busy=1 from E+1 through E+WIDTH.
  - At E+WIDTH+1: {result_hi,result_lo} = full product, done=1, busy=0, state returns to IDLE.
- DIVU, start at E: restoring division over WIDTH iterations, same timing as MULU.
  - result_lo = quotient, result_hi = remainder.
  - If data_b == 0: still takes full latency; quotient = all ones, remainder = data_a, div_zero=1.
- zero is computed on result_lo for all ops. overflow=0 for MULU/DIVU.
- div_zero is cleared by the next accepted start.
- start while busy (MUL/DIV/DONE) is ignored, never queued; the pipeline must hold it.
- ctl=101 behaves as AND and sets no flags.
- All outputs other than done hold their value until the next accepted op completes.
- done is never high for two consecutive cycles from one op.

Optional Feature:
- Macro: ALU_MUL_EARLY_EXIT_EN.
- Defined: MUL leaves for DONE after the first iteration in which the shifted multiplier becomes 0.
  - Iterations = index of highest set bit of data_b + 1, minimum 1 (so data_b=0 takes 1 iteration).
  - done arrives at E+iterations+1.
  - DIVU latency is unchanged.
- Undefined: MUL always runs exactly WIDTH iterations.
- The result value is identical in both builds.

Test Plan (WIDTH=8 unless stated):
- rst=1 mid-MULU at iteration 3 -> next cycle: busy=0, done=0, all outputs 0; a new start is accepted on the following cycle.
- ADD 0x7F+0x01 -> E+1: result_lo=0x80, overflow=1, zero=0, done=1. SUB 0x05-0x05 -> result_lo=0x00, zero=1. SLT A=0x80, B=0x7F -> result_lo=0x01.
- MULU 0xFF*0xFF, start at E -> busy high E+1..E+8; E+9: result_hi=0xFE, result_lo=0x01, done=1 for one cycle.
- DIVU 200/7 -> E+9: result_lo=28 (0x1C), result_hi=4. DIVU 0x5A/0 -> result_lo=0xFF, result_hi=0x5A, div_zero=1.
- start held high with a new opcode throughout a MULU -> ignored while busy; the new op is accepted at the cycle after done; the MULU result is unaffected.
- With ALU_MUL_EARLY_EXIT_EN defined: MULU 0x23*0x03 -> done at E+3, result {0x00,0x69}. MULU by 0 -> done at E+2, result 0.
